// File: rtl/key_debouncer.sv
// key_debouncer
//   Debounces an active-low, asynchronous push-button and produces a clean
//   pressed level, one-cycle press/release strobes and an optional
//   auto-repeat strobe while the key stays held.
//
// Ports
//   clk           in   sole clock, rising edge
//   rst           in   synchronous reset, active high
//   key_n_raw     in   raw bouncing button, 0 = pressed (asynchronous)
//   key_level     out  debounced pressed level (1 = pressed), registered
//   press_pulse   out  one-cycle strobe on an accepted press
//   release_pulse out  one-cycle strobe on an accepted release
//   repeat_pulse  out  one-cycle auto-repeat strobe while held
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n_raw,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  // Two-flop synchronizer; resets to the released level so k_s starts at 0.
  logic [1:0] sync_q;
  logic       k_s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n_raw};
  end

  assign k_s = ~sync_q[1];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rpt_q, rpt_d;

  // State register (also holds counters and registered outputs)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      rel_q       <= 1'b0;
      rpt_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
      level_q     <= level_d;
      press_q     <= press_d;
      rel_q       <= rel_d;
      rpt_q       <= rpt_d;
    end
  end

  // Next-state logic with debounce counter. The counter holds the number of
  // agreeing samples already seen in a WAIT state; the sample that makes it
  // reach DEBOUNCE_CYCLES commits the transition on the same edge.
  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt_q;
    unique case (state_q)
      IDLE: begin
        db_cnt_d = '0;
        if (k_s) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!k_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        db_cnt_d = '0;
        if (!k_s) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (k_s) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // Output logic. Outputs are registered from state_d so they line up with
  // the state register. The repeat counter only advances on edges that land
  // in HELD, so time in RELEASE_WAIT shifts the schedule by exactly the
  // cycles spent there and no repeat can be emitted into RELEASE_WAIT.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    rpt_d       = 1'b0;
    press_d     = (state_q == PRESS_WAIT)   && (state_d == HELD);
    rel_d       = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    level_d     = (state_d == HELD) || (state_d == RELEASE_WAIT);

    if (press_d) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (state_d == HELD) begin
      // Counter restarts on every hit, even with repeat disabled, so it never wraps.
      if (rpt_cnt_q == (rpt_first_q ? DLY_LAST : PER_LAST)) begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
        rpt_d       = (REPEAT_EN != 0);
      end else begin
        rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
      end
    end else if (state_d == IDLE) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end
  end

  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rpt_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Two instances share the stimulus: dut1 has auto-repeat
// enabled, dut0 has it disabled (repeat_pulse must stay 0 there while the
// level/press/release behaviour is identical).
module tb_key_debouncer;

  logic clk = 1'b0;
  logic rst;
  logic key_n;
  logic lvl1, pr1, rl1, rp1;
  logic lvl0, pr0, rl0, rp0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10),
                  .REPEAT_PERIOD(3), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .key_n_raw(key_n),
    .key_level(lvl1), .press_pulse(pr1), .release_pulse(rl1), .repeat_pulse(rp1));

  key_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10),
                  .REPEAT_PERIOD(3), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .key_n_raw(key_n),
    .key_level(lvl0), .press_pulse(pr0), .release_pulse(rl0), .repeat_pulse(rp0));

  typedef struct {
    bit r;
    bit k;
    bit lvl;
    bit pr;
    bit rl;
    bit rp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit k, bit lvl, bit pr, bit rl, bit rp);
    vec_t v;
    v.r = r; v.k = k; v.lvl = lvl; v.pr = pr; v.rl = rl; v.rp = rp;
    vecs.push_back(v);
  endfunction

  // One clock: drive inputs on the falling edge, sample 1 time unit after the
  // rising edge, compare both instances (dut0 always expects repeat 0).
  task automatic cyc(input bit r, input bit k, input bit lvl, input bit pr,
                     input bit rl, input bit rp, input string name);
    logic [3:0] exp1, exp0;
    @(negedge clk);
    rst   = r;
    key_n = k;
    @(posedge clk);
    #1;
    exp1 = {lvl, pr, rl, rp};
    exp0 = {lvl, pr, rl, 1'b0};
    checks++;
    if ({lvl1, pr1, rl1, rp1} !== exp1) begin
      errors++;
      $display("FAIL %s rep_en=1 {lvl,press,rel,rpt} got %b expected %b", name,
               {lvl1, pr1, rl1, rp1}, exp1);
    end
    checks++;
    if ({lvl0, pr0, rl0, rp0} !== exp0) begin
      errors++;
      $display("FAIL %s rep_en=0 {lvl,press,rel,rpt} got %b expected %b", name,
               {lvl0, pr0, rl0, rp0}, exp0);
    end
  endtask

  // From IDLE, key held low: press strobe on edge 7.
  task automatic press_seq(input string name);
    for (int e = 1; e <= 6; e++) cyc(0, 0, 0, 0, 0, 0, name);
    cyc(0, 0, 1, 1, 0, 0, name);
  endtask

  // From HELD, key released: release strobe on edge 7, gone on edge 8.
  // Callers start this only where no repeat is due in the first two edges.
  task automatic release_seq(input string name);
    for (int e = 1; e <= 6; e++) cyc(0, 1, 1, 0, 0, 0, name);
    cyc(0, 1, 0, 0, 1, 0, name);
    cyc(0, 1, 0, 0, 0, 0, name);
  endtask

  function automatic bit rpt_plain(int k);
    return (k >= 10) && ((k - 10) % 3 == 0);
  endfunction

  initial begin
    rst   = 1'b1;
    key_n = 1'b1;

    // Table: reset state, clean press, short hold, clean release.
    add(1, 1, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);
    for (int e = 1; e <= 6; e++) add(0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0);          // edge 7: level up + press strobe
    add(0, 0, 1, 0, 0, 0);          // edge 8: strobe gone
    add(0, 0, 1, 0, 0, 0);
    for (int e = 1; e <= 6; e++) add(0, 1, 1, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0);          // release edge 7
    add(0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0);

    foreach (vecs[i]) cyc(vecs[i].r, vecs[i].k, vecs[i].lvl, vecs[i].pr,
                          vecs[i].rl, vecs[i].rp, "table");

    // Bounce: 0,1,0,1 then stable 0; stable 0 first sampled is edge 1.
    cyc(0, 0, 0, 0, 0, 0, "bounce");
    cyc(0, 1, 0, 0, 0, 0, "bounce");
    cyc(0, 0, 0, 0, 0, 0, "bounce");
    cyc(0, 1, 0, 0, 0, 0, "bounce");
    press_seq("bounce_press");
    release_seq("bounce_release");

    // Repeat schedule: press strobe at k=0, repeats at 10,13,...,28.
    press_seq("rpt_press");
    for (int k = 1; k <= 28; k++) cyc(0, 0, 1, 0, 0, rpt_plain(k), "rpt_hold");
    release_seq("rpt_release");   // edges 29,30 carry no repeat

    // Release glitch: two high samples at k=12,13 -> two cycles in
    // RELEASE_WAIT, schedule after 13 shifts by 2 (18, 21, 24).
    press_seq("glitch_press");
    for (int k = 1; k <= 24; k++) begin
      bit kn, rp;
      kn = (k == 12) || (k == 13);
      rp = (k == 10) || (k == 13) || (k == 18) || (k == 21) || (k == 24);
      cyc(0, kn, 1, 0, 0, rp, "glitch_hold");
    end
    release_seq("glitch_release"); // edges 25,26 carry no repeat

    // Reset during PRESS_WAIT with key still held low.
    for (int e = 1; e <= 4; e++) cyc(0, 0, 0, 0, 0, 0, "rst_pre");
    for (int e = 1; e <= 3; e++) cyc(1, 0, 0, 0, 0, 0, "rst_during");
    press_seq("rst_press");
    release_seq("rst_release");

    // Long hold (50 cycles): dut0 must never repeat, dut1 follows schedule.
    press_seq("long_press");
    for (int k = 1; k <= 49; k++) cyc(0, 0, 1, 0, 0, rpt_plain(k), "long_hold");
    release_seq("long_release");   // edges 50,51 carry no repeat

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL be the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter REPEAT_EN, default 1, SHALL enable auto-repeat when 1; when 0, repeat_pulse SHALL stay 0.
REQ-003 Parameter REPEAT_DELAY, default 25000000, SHALL be the number of cycles from press_pulse to the first repeat_pulse.
REQ-004 Parameter REPEAT_PERIOD, default 5000000, SHALL be the number of cycles between successive repeat_pulses; minimum value 1.
REQ-005 Parameter CNT_W, default 25, SHALL be the width of all internal counters, wide enough for the largest of the three counts.
REQ-006 Port clk, input, 1 bit: sole clock; all logic SHALL operate on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port key_n_raw, input, 1 bit: asynchronous, bouncing push-button, active-low (0 = pressed).
REQ-009 Port key_level, output, 1 bit: registered, debounced, active-high pressed level.
REQ-010 Port press_pulse, output, 1 bit: registered one-cycle strobe on an accepted press.
REQ-011 Port release_pulse, output, 1 bit: registered one-cycle strobe on an accepted release.
REQ-012 Port repeat_pulse, output, 1 bit: registered one-cycle auto-repeat strobe while held.

Function
REQ-013 key_n_raw SHALL pass through a two-flop synchronizer and be inverted, giving k_s (1 = pressed); no other logic SHALL read key_n_raw.
REQ-014 The FSM SHALL have exactly four states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE: k_s=1 -> PRESS_WAIT with the debounce counter restarted; otherwise remain.
REQ-016 PRESS_WAIT: any k_s=0 sample -> IDLE with no output change; DEBOUNCE_CYCLES consecutive k_s=1 samples -> HELD.
REQ-017 HELD: k_s=0 -> RELEASE_WAIT with the debounce counter restarted; otherwise remain.
REQ-018 RELEASE_WAIT: any k_s=1 sample -> HELD without any pulse, and the repeat schedule SHALL resume unchanged; DEBOUNCE_CYCLES consecutive k_s=0 samples -> IDLE.
REQ-019 Press latency: with key_n_raw held low, key_level SHALL read 1 and press_pulse SHALL be high immediately after rising edge DEBOUNCE_CYCLES+3, counting the first edge that samples key_n_raw=0 as edge 1.
REQ-020 Release latency SHALL mirror REQ-019: key_level falls and release_pulse is high immediately after edge DEBOUNCE_CYCLES+3.
REQ-021 Each of press_pulse, release_pulse and repeat_pulse SHALL be high for exactly one cycle per event; at most one of the three SHALL be high in any cycle.
REQ-022 key_level SHALL be 1 exactly while the state is HELD or RELEASE_WAIT.
REQ-023 Repeat: the first repeat_pulse SHALL occur REPEAT_DELAY cycles after the press_pulse cycle, then every REPEAT_PERIOD cycles while the state remains HELD.
REQ-024 The repeat counter SHALL freeze during RELEASE_WAIT, delaying the repeat schedule by the cycles spent there; no repeat_pulse SHALL occur in RELEASE_WAIT.
REQ-025 Counters SHALL never wrap; each is restarted on every state transition that uses it.

Reset
REQ-026 While rst=1 at a clock edge: synchronizer flops SHALL reset to the released value (k_s=0), state to IDLE, all counters to 0, and all four outputs to 0.
REQ-027 A reset applied mid-press SHALL discard any partial debounce and produce no pulse; if the key is still held after reset, a full press sequence per REQ-019 SHALL follow, including press_pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-028 Clean press: key_n_raw 1->0 and held -> key_level=1 and press_pulse=1 after edge 7; press_pulse=0 after edge 8.
REQ-029 Bounce: key_n_raw toggles 0,1,0,1 on alternate cycles, then held 0 -> no pulse during the toggling; press_pulse exactly 7 edges after the final stable 0 is first sampled.
REQ-030 Repeat: hold the key for 30 cycles after press_pulse -> repeat_pulse 10, 13, 16, 19, 22, 25 and 28 cycles after press_pulse; release then yields a single release_pulse and no further repeat_pulse.
REQ-031 Release glitch: while HELD, key_n_raw high for 2 cycles then low -> key_level stays 1, no release_pulse, and the repeat schedule shifts by exactly the cycles spent in RELEASE_WAIT.
REQ-032 Reset mid-operation: assert rst during PRESS_WAIT with key_n_raw held low, then release rst -> all outputs 0 during reset; press_pulse after edge 7 counted from the first post-reset edge.
REQ-033 REPEAT_EN=0: hold the key for 50 cycles -> repeat_pulse never asserts; press and release pulses are unchanged.
